// File: rtl/mips_seq_divider.sv
// -----------------------------------------------------------------------------
// mips_seq_divider
//   Multi-cycle restoring divider for the MIPS DIV/DIVU path. One quotient bit
//   is produced per clock, so a divide takes WIDTH cycles from the start edge
//   to the done pulse. The quotient feeds LO and the remainder feeds HI.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CNT_W  iteration counter width (2**CNT_W > WIDTH)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        divide request, sampled only while idle
//   is_signed    1 = DIV (two's complement), 0 = DIVU; sampled with start
//   dividend     numerator; sampled with start
//   divisor      denominator; sampled with start
//   busy         high while a divide is in progress
//   done         one-cycle pulse when the results become valid
//   quotient     LO result, held until the next done
//   remainder    HI result, held until the next done
//   div_by_zero  set with done when the divisor was zero, held until next done
// -----------------------------------------------------------------------------
module mips_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_last_step;

  // Operation context captured at start.
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;      // partial remainder; always < divisor magnitude
  logic [WIDTH-1:0] r_dvd;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dsr;      // divisor magnitude
  logic [WIDTH-1:0] r_raw_dvd;  // untouched dividend, returned on divide by zero
  logic             r_neg_quo;
  logic             r_neg_rem;
  logic             r_dz;

  // Registered results.
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  // Operand magnitudes. The negate is plain WIDTH-bit two's complement, so the
  // most negative value maps onto itself and is then read as unsigned 2**(WIDTH-1).
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dsr_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dsr_mag = w_dsr_neg ? -divisor  : divisor;

  // One restoring step. The shifted remainder needs WIDTH+1 bits; the trial
  // difference then lies in (-divisor, divisor), so its top bit is the sign.
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;

  assign w_shift_rem = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dsr};
  assign w_q_bit     = ~w_trial[WIDTH];
  assign w_rem_next  = w_q_bit ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
  assign w_dvd_next  = {r_dvd[WIDTH-2:0], w_q_bit};

  // Sign correction on the final magnitudes: truncation toward zero, with the
  // remainder taking the dividend's sign.
  logic [WIDTH-1:0] w_quo_fixed;
  logic [WIDTH-1:0] w_rem_fixed;

  assign w_quo_fixed = r_neg_quo ? -w_dvd_next : w_dvd_next;
  assign w_rem_fixed = r_neg_rem ? -w_rem_next : w_rem_next;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    w_next_state = r_state;
    w_last_step  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_CALC;
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last_step  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dsr         <= '0;
      r_raw_dvd     <= '0;
      r_neg_quo     <= 1'b0;
      r_neg_rem     <= 1'b0;
      r_dz          <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg_quo <= w_dvd_neg ^ w_dsr_neg;
            r_neg_rem <= w_dvd_neg;
            r_dz      <= (divisor == '0);
            r_raw_dvd <= dividend;
            r_dvd     <= w_dvd_mag;
            r_dsr     <= w_dsr_mag;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(WIDTH);
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt - 1'b1;
          if (w_last_step) begin
            r_done        <= 1'b1;
            // A zero divisor still runs the full loop; its results are overridden.
            r_quotient    <= r_dz ? '1 : w_quo_fixed;
            r_remainder   <= r_dz ? r_raw_dvd : w_rem_fixed;
            r_div_by_zero <= r_dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_mips_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_mips_seq_divider
//   Directed and random divides against mips_seq_divider. Expected results are
//   pushed to a scoreboard when a divide is started and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_mips_seq_divider;

  localparam int W        = 32;
  localparam int LAT      = 32;
  localparam int MAX_WAIT = 40;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         start     = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend  = '0;
  logic [W-1:0] divisor   = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  mips_seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference model built on the simulator's own division operators.
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    e.q  = q;
    e.r  = r;
    e.dz = (b == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge E0.
  task automatic start_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input bit track);
    exp_t e;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    if (track) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency/busy, then pops and compares.
  // With inject set, a second start with other operands is raised for E5.
  task automatic wait_result(input string tag, input bit inject);
    int   c       = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!done && c < MAX_WAIT) begin
      if (inject && c == 4) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd999;
        divisor   = 32'd3;
      end
      if (inject && c == 5) start = 1'b0;
      @(negedge clk);
      c++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, c, LAT);
    check({tag, "_busy_window"}, {31'd0, busy_ok}, 1);
    check({tag, "_busy_low"}, {31'd0, busy}, 0);
    check({tag, "_sb_size"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, quotient, e.q);
      check({tag, "_remainder"}, remainder, e.r);
      check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
    end
  endtask

  initial begin
    exp_t         m;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           pulses;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dz", {31'd0, div_by_zero}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Unsigned 100 / 7, then results hold and done drops.
    start_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    check("u100_busy_after_start", {31'd0, busy}, 1);
    wait_result("u100_7", 1'b0);
    @(negedge clk);
    check("u100_done_cleared", {31'd0, done}, 0);
    check("u100_quotient_held", quotient, 32'd14);

    // Signed truncation toward zero.
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_result("s_m7_2", 1'b0);
    @(negedge clk);
    start_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
    wait_result("s_7_m2", 1'b0);
    @(negedge clk);

    // Overflow and unsigned extreme.
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_result("s_ovf", 1'b0);
    @(negedge clk);
    start_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    wait_result("u_max_1", 1'b0);
    @(negedge clk);

    // Divide by zero in both modes, then a valid divide clears the flag.
    start_div(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1);
    wait_result("s_dz", 1'b0);
    @(negedge clk);
    start_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b1);
    wait_result("u_dz", 1'b0);
    @(negedge clk);
    check("dz_held_idle", {31'd0, div_by_zero}, 1);
    start_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    wait_result("u50_5", 1'b0);
    @(negedge clk);

    // A start while busy is ignored.
    start_div(1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1'b1);
    wait_result("busy_start", 1'b1);

    // Back-to-back: a new start in the done cycle.
    start_div(1'b0, 32'd81, 32'd4, 32'd20, 32'd1, 1'b0, 1'b1);
    wait_result("b2b_first", 1'b0);
    start_div(1'b1, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_result("b2b_second", 1'b0);
    @(negedge clk);

    // Random operands against the model.
    for (int i = 0; i < 8; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      m   = model(sgn, a, b);
      start_div(sgn, a, b, m.q, m.r, m.dz, 1'b1);
      wait_result($sformatf("rand%0d", i), 1'b0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a divide.
    start_div(1'b0, 32'd5000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    start_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1);
    wait_result("u1000_10", 1'b0);
    @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
